// File: rtl/animation_sequencer_pkg.sv
// animation_sequencer_pkg: shared FSM state type and datapath widths for the animation sequencer.
package animation_sequencer_pkg;
    typedef enum logic [1:0] {ST_RUN, ST_PAUSE, ST_SWITCH} state_t;
    localparam int ANI_W = 6;
    localparam int FRAME_W = 6;
    localparam int NUM_ANI_DEF = 56;
endpackage

// File: rtl/animation_sequencer_frame_prescaler.sv
// frame_prescaler: frame period counter, DIV_BASE*(speed+1) cycles per tick, with clear and hold.
module frame_prescaler #(
    parameter int DIV_BASE = 1_000_000,
    parameter int PRESCALE_W = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] speed,
    input  logic       clear,
    input  logic       hold,
    output logic       tick
);
    logic [PRESCALE_W-1:0] cnt, term;
    assign term = PRESCALE_W'(DIV_BASE * (int'(speed) + 1) - 1);
    // >= keeps the counter bounded if speed drops while counting
    assign tick = !hold && cnt >= term;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (ena)
            cnt <= clear ? '0 : hold ? cnt : tick ? '0 : cnt + PRESCALE_W'(1);
endmodule

// File: rtl/animation_sequencer.sv
// animation_sequencer: frame timing, frame wrap and animation select (manual / auto-cycle).
// Define ANISEQ_RANDOM_EN for an LFSR-driven auto-mode target instead of animation+1.
module animation_sequencer
    import animation_sequencer_pkg::*;
#(
    parameter int DIV_BASE = 1_000_000,
    parameter int PRESCALE_W = 24,
    parameter int NUM_ANI = NUM_ANI_DEF,
    parameter int DWELL_LOOPS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic [ANI_W-1:0]   sel_ani,
    input  logic               next_btn,
    input  logic               pause,
    input  logic [3:0]         speed,
    input  logic [FRAME_W-1:0] limit,
    output logic [ANI_W-1:0]   animation,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_tick,
    output logic               loop_done
);
    localparam int LOOP_W = $clog2(DWELL_LOOPS + 1);
    state_t state, state_nx;
    logic [ANI_W-1:0] auto_t, target_q;
    logic [LOOP_W-1:0] loop_cnt;
    logic [FRAME_W-1:0] lim_m1;
    logic btn_q, tick, req, wrap, dwell_done, hold, clr, adv;

    frame_prescaler #(.DIV_BASE(DIV_BASE), .PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk(clk), .rst_n(rst_n), .ena(ena), .speed(speed),
        .clear(clr), .hold(hold), .tick(tick)
    );

    assign lim_m1 = (limit == '0) ? '0 : limit - FRAME_W'(1);
    assign wrap = frame >= lim_m1;
    assign dwell_done = state == ST_RUN && loop_cnt == LOOP_W'(DWELL_LOOPS);
    assign req = state != ST_SWITCH &&
                 (mode ? ((next_btn && !btn_q) || dwell_done) : sel_ani != animation);

`ifdef ANISEQ_RANDOM_EN
    logic [ANI_W-1:0] lfsr, lfsr_nx, rnd;
    assign lfsr_nx = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    assign rnd = lfsr_nx >= ANI_W'(NUM_ANI) ? lfsr_nx - ANI_W'(NUM_ANI) : lfsr_nx;
    assign auto_t = rnd != animation ? rnd : rnd == ANI_W'(NUM_ANI - 1) ? '0 : rnd + ANI_W'(1);
    // the target latched at request already used lfsr_nx, so commit it on the switch
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            lfsr <= 6'h01;
        else if (ena && state == ST_SWITCH)
            lfsr <= lfsr_nx;
`else
    assign auto_t = animation == ANI_W'(NUM_ANI - 1) ? '0 : animation + ANI_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= ST_RUN;
        else if (ena)
            state <= state_nx;

    always_comb
        state_nx = state == ST_SWITCH ? (pause ? ST_PAUSE : ST_RUN) :
                   req ? ST_SWITCH : pause ? ST_PAUSE : ST_RUN;

    // a request in a tick cycle swallows the tick
    always_comb begin
        hold = state != ST_RUN || pause;
        clr = state == ST_SWITCH;
        adv = tick && !req;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            animation <= '0;
            frame <= '0;
            frame_tick <= 1'b0;
            loop_done <= 1'b0;
            loop_cnt <= '0;
            btn_q <= 1'b0;
            target_q <= '0;
        end else if (!ena) begin
            frame_tick <= 1'b0;
            loop_done <= 1'b0;
        end else begin
            btn_q <= next_btn;
            frame_tick <= adv;
            loop_done <= adv && wrap;
            if (req)
                target_q <= mode ? auto_t : sel_ani;
            if (clr) begin
                animation <= target_q;
                frame <= '0;
                loop_cnt <= '0;
            end else if (adv) begin
                frame <= wrap ? '0 : frame + FRAME_W'(1);
                if (wrap && mode && loop_cnt != LOOP_W'(DWELL_LOOPS))
                    loop_cnt <= loop_cnt + LOOP_W'(1);
            end
        end
endmodule

// File: doc/animation_sequencer.md
# animation_sequencer

Sequencer for the 7-segment animation engine. Times frame steps with a programmable prescaler, advances the frame index and wraps it at the current animation's frame limit, and selects the active animation, either manually from the input pins or by auto-cycling after a fixed number of loops. Its `animation` output drives the per-animation frame-limit lookup, and the returned `limit` comes back in. Its `frame`/`animation` outputs address the segment pattern ROM.

## Interface
- `DIV_BASE`, default 1_000_000: prescaler base count, in clock cycles per frame at `speed`=0.
- `PRESCALE_W`, default 24: prescaler counter width. Must hold `DIV_BASE*16-1`.
- `NUM_ANI`, default 56: number of valid animation ids (0..NUM_ANI-1).
- `DWELL_LOOPS`, default 4: complete loops of an animation before auto-advance.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  global enable. Low freezes every register.
- `mode`  in  1  0 = manual (follow `sel_ani`), 1 = auto-cycle.
- `sel_ani`  in  6  manual animation select.
- `next_btn`  in  1  synchronous level. A rising edge requests an advance (auto mode only).
- `pause`  in  1  high holds the frame index.
- `speed`  in  4  frame period = `DIV_BASE*(speed+1)` cycles.
- `limit`  in  6  frame count of the current `animation` (combinational lookup).
- `animation`  out  6  active animation id.
- `frame`  out  6  current frame index.
- `frame_tick`  out  1  one-cycle pulse on each frame advance.
- `loop_done`  out  1  one-cycle pulse when `frame` wraps to 0.

## Operation
- States: `ST_RUN`, `ST_PAUSE`, `ST_SWITCH`. Reset state is `ST_RUN`.
- **ST_RUN**
  - Prescaler counts 0..`DIV_BASE*(speed+1)-1`. At the terminal count it clears and generates a tick.
  - On tick: if `frame >= limit-1`, then `frame`←0, `loop_done`=1, and the loop counter increments. Otherwise `frame`←`frame+1`.
  - `frame_tick`=1 on every tick.
  - `limit` of 0 or 1 is treated as 1: `frame` stays 0 and `loop_done` pulses every tick.
- **ST_PAUSE**
  - Entered from RUN when `pause`=1. Prescaler and `frame` hold.
  - Returns to RUN when `pause`=0.
- **Switch requests**, evaluated in RUN and PAUSE:
  - Manual mode: a request occurs when `sel_ani != animation`. Target is `sel_ani`. Ids ≥ NUM_ANI are accepted as-is, and the lookup's default limit applies.
  - Auto mode: a request occurs on a `next_btn` rising edge, or when the loop counter reaches `DWELL_LOOPS` in RUN. Target is `animation+1`, wrapping from NUM_ANI-1 to 0.
  - If a request and a tick/wrap occur in the same cycle, the request wins: exactly one advance, and the tick is discarded.
- **ST_SWITCH** (one cycle): `animation`←target; `frame`, prescaler and loop counter ←0. Next state is PAUSE if `pause`, else RUN.
- A `mode` change takes effect on the next request evaluation. It does not cause a spurious advance.

## Timing
- Reset values: `animation`=0, `frame`=0, `frame_tick`=0, `loop_done`=0, prescaler=0, loop counter=0, `next_btn` edge register=0.
- `frame_tick` and `loop_done` are registered. They are high in the same cycle that `frame` shows its new value.
- Tick-to-frame latency is 1 cycle: terminal count at cycle N, new `frame` at N+1.
- Switch latency is 2 cycles: request at cycle N, ST_SWITCH at N+1, new `animation` and `frame`=0 visible at N+2.
- `limit` is sampled combinationally in the same cycle as the wrap compare.
- `ena`=0: all state, prescaler and edge detector hold. Pulses are forced to 0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).

## Configuration
- `ANISEQ_RANDOM_EN` defined: the auto-mode target comes from a 6-bit LFSR (x^6+x^5+1, reset seed 6'h01), which steps once per switch. A value ≥ NUM_ANI has NUM_ANI subtracted. A value equal to the current `animation` is incremented by 1, modulo NUM_ANI.
- Undefined: auto target is `animation+1`, and no LFSR is instantiated.

## Structure
- Shared package: the state enum (`ST_RUN`/`ST_PAUSE`/`ST_SWITCH`), the `ANI_W`=6 and `FRAME_W`=6 widths, and the NUM_ANI default.
- One sub-module, `frame_prescaler`: counter plus terminal-count compare, with `clear`/`hold` inputs and a `tick` output.

## Test plan
- Reset, then `mode`=0, `sel_ani`=0, `limit`=10, `speed`=0, DIV_BASE=4 → a tick every 4 cycles; `frame` runs 0..9, then 0 with `loop_done`=1.
- `sel_ani` 0→5 at cycle N → `animation`=5 and `frame`=0 at N+2; the prescaler restarts.
- `mode`=1, `limit`=2, DWELL_LOOPS=4 → `animation` increments after 8 ticks. Starting at `animation`=55 (NUM_ANI=56), it wraps to 0.
- `next_btn` rising edge in the same cycle as a loop-count-triggered advance → `animation` increases by exactly 1.
- `pause`=1 mid-frame for 20 cycles → `frame`/prescaler unchanged, no pulses; the tick resumes the remaining count after release.
- `rst_n` pulse during ST_SWITCH → all outputs 0 immediately. With `ANISEQ_RANDOM_EN`, the first auto target after reset is the LFSR value after one step from 6'h01.
